// File: rtl/dmem_cache.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Fills and evicts whole 128-bit lines over a request/busywait memory port.
module dmem_cache #(
    parameter int LINES = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    input  logic [3:0]   READ_WRITE,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 28 - IDXW;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t              state_q;
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAGW-1:0]     tag_q  [LINES];
    logic [127:0]        data_q [LINES];
    logic                mem_read_q;
    logic                mem_write_q;
    logic [27:0]         mem_addr_q;
    logic [127:0]        mem_wdata_q;

    logic [IDXW-1:0]     idx;
    logic [TAGW-1:0]     tag;
    logic [1:0]          word;
    logic                rd;
    logic                wr;
    logic                acc;
    logic                hit;
    logic [3:0]          be;
    logic [31:0]         wd;
    logic [127:0]        line_d;

    assign idx  = ADDRESS[4 +: IDXW];
    assign tag  = ADDRESS[31 -: TAGW];
    assign word = ADDRESS[3:2];
    assign rd   = (READ_WRITE[3:2] == 2'b01);
    assign wr   = (READ_WRITE[3:2] == 2'b10);
    assign acc  = rd | wr;
    assign hit  = acc && valid_q[idx] && (tag_q[idx] == tag);

    assign BUSYWAIT      = (acc && !hit) || (state_q != IDLE);
    assign READDATA      = data_q[idx][word*32 +: 32];
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;

    // Replicate store data across lanes so the byte enables alone pick the slot.
    always_comb begin
        be = 4'b1111;
        wd = WRITEDATA;
        unique case (READ_WRITE[1:0])
            2'b00: begin
                be = 4'b0001 << ADDRESS[1:0];
                wd = {4{WRITEDATA[7:0]}};
            end
            2'b01: begin
                be = ADDRESS[1] ? 4'b1100 : 4'b0011;
                wd = {2{WRITEDATA[15:0]}};
            end
            default: ;
        endcase
        line_d = data_q[idx];
        for (int k = 0; k < 16; k++) begin
            if (be[k%4] && ((k / 4) == int'(word)))
                line_d[k*8 +: 8] = wd[(k%4)*8 +: 8];
        end
    end

    // Data array is never cleared; valid bits alone guard it.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state_q == IDLE && wr && hit)
                data_q[idx] <= line_d;
            else if (state_q == FETCH && !MEM_BUSYWAIT)
                data_q[idx] <= MEM_READDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (wr && hit) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (acc && !hit) begin
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx};
                            mem_wdata_q <= data_q[idx];
                        end else begin
                            state_q    <= FETCH;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= ADDRESS[31:4];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q     <= FETCH;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= ADDRESS[31:4];
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q      <= IDLE;
                        mem_read_q   <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        tag_q[idx]   <= tag;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_cache.sv
// Directed bench for dmem_cache with a fixed-latency line memory model.
module tb_dmem_cache;

    logic         clk = 1'b0;
    logic         RESET;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITEDATA;
    logic [3:0]   READ_WRITE;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    logic [127:0] mem [16];
    logic [127:0] wb_line;
    logic [27:0]  wb_addr;
    logic         wb_valid;
    logic         hold_busy;
    int           cnt;
    int           n_checks;
    int           n_fail;

    localparam logic [3:0] RD_W = 4'b0110;
    localparam logic [3:0] WR_B = 4'b1000;
    localparam logic [3:0] WR_H = 4'b1001;
    localparam logic [3:0] WR_W = 4'b1010;

    dmem_cache #(.LINES(8)) dut (
        .CLK(clk), .RESET(RESET), .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
        .READ_WRITE(READ_WRITE), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 clk = ~clk;

    // Memory: busy for 5 cycles after a request appears, then completes.
    assign MEM_BUSYWAIT = hold_busy || ((MEM_READ || MEM_WRITE) && cnt < 5);
    assign MEM_READDATA = (wb_valid && MEM_ADDRESS == wb_addr) ? wb_line
                                                               : mem[MEM_ADDRESS[3:0]];

    always @(posedge clk) begin
        if (MEM_READ || MEM_WRITE) begin
            if (!MEM_BUSYWAIT) begin
                cnt <= 0;
                if (MEM_WRITE) begin
                    wb_valid <= 1'b1;
                    wb_addr  <= MEM_ADDRESS;
                    wb_line  <= MEM_WRITEDATA;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    task automatic test_reset();
        RESET = 1'b1;
        READ_WRITE = 4'b0000;
        ADDRESS = 32'h0;
        WRITEDATA = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b rd=%b wr=%b, required 0 0 0",
                     BUSYWAIT, MEM_READ, MEM_WRITE);
        end
        n_checks++;
        if (MEM_ADDRESS !== 28'h0 || MEM_WRITEDATA !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h data=%h, required 0", MEM_ADDRESS, MEM_WRITEDATA);
        end
        RESET = 1'b0;
    endtask

    task automatic test_read_miss();
        logic seen_rd;
        int   waited;
        seen_rd = 1'b0;
        waited = 0;
        @(negedge clk);
        ADDRESS = 32'h40;
        READ_WRITE = RD_W;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_busy_same_cycle: busy=%b, required 1", BUSYWAIT);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            waited = i + 1;
            if (MEM_READ && !seen_rd) begin
                seen_rd = 1'b1;
                n_checks++;
                if (MEM_ADDRESS !== 28'h4 || MEM_WRITE !== 1'b0) begin
                    n_fail++;
                    $display("FAIL miss_fetch_addr: addr=%h wr=%b, required 0000004 0",
                             MEM_ADDRESS, MEM_WRITE);
                end
            end
            if (!BUSYWAIT) break;
        end
        n_checks++;
        if (!seen_rd || BUSYWAIT !== 1'b0 || waited != 7) begin
            n_fail++;
            $display("FAIL miss_latency: seen_rd=%b busy=%b cycles=%0d, required 1 0 7",
                     seen_rd, BUSYWAIT, waited);
        end
        n_checks++;
        if (READDATA !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL miss_readdata: got %h, required aabbccdd", READDATA);
        end
    endtask

    task automatic test_read_hit();
        @(negedge clk);
        ADDRESS = 32'h48;
        READ_WRITE = RD_W;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0 || READDATA !== 32'h22222222) begin
            n_fail++;
            $display("FAIL hit_word2: busy=%b data=%h, required 0 22222222", BUSYWAIT, READDATA);
        end
        @(negedge clk);
        ADDRESS = 32'h40;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0 || READDATA !== 32'hAABBCCDD || MEM_READ !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_word0: busy=%b data=%h rd=%b, required 0 aabbccdd 0",
                     BUSYWAIT, READDATA, MEM_READ);
        end
    endtask

    task automatic test_store_merge();
        @(negedge clk);
        ADDRESS = 32'h41;
        WRITEDATA = 32'hDEADBE5A;
        READ_WRITE = WR_B;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_hit_busy: busy=%b, required 0", BUSYWAIT);
        end
        @(negedge clk);
        ADDRESS = 32'h42;
        WRITEDATA = 32'h77771234;
        READ_WRITE = WR_H;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_hit_busy: busy=%b, required 0", BUSYWAIT);
        end
        @(negedge clk);
        ADDRESS = 32'h40;
        READ_WRITE = RD_W;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0 || READDATA !== 32'h12345ADD) begin
            n_fail++;
            $display("FAIL store_merge: busy=%b data=%h, required 0 12345add", BUSYWAIT, READDATA);
        end
        @(negedge clk);
        ADDRESS = 32'h44;
        #1;
        n_checks++;
        if (READDATA !== 32'h11111111) begin
            n_fail++;
            $display("FAIL store_neighbour: got %h, required 11111111", READDATA);
        end
    endtask

    task automatic test_dirty_miss();
        logic seen_wr;
        logic seen_rd;
        int   waited;
        seen_wr = 1'b0;
        seen_rd = 1'b0;
        waited = 0;
        @(negedge clk);
        ADDRESS = 32'hC0;
        READ_WRITE = RD_W;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            waited = i + 1;
            if (MEM_WRITE && !seen_wr) begin
                seen_wr = 1'b1;
                n_checks++;
                if (seen_rd || MEM_ADDRESS !== 28'h4 || MEM_WRITEDATA[31:0] !== 32'h12345ADD
                    || MEM_READ !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wb_request: seen_rd=%b addr=%h w0=%h rd=%b, required 0 0000004 12345add 0",
                             seen_rd, MEM_ADDRESS, MEM_WRITEDATA[31:0], MEM_READ);
                end
            end
            if (MEM_READ && !seen_rd) begin
                seen_rd = 1'b1;
                n_checks++;
                if (!seen_wr || MEM_ADDRESS !== 28'hC) begin
                    n_fail++;
                    $display("FAIL wb_then_fetch: seen_wr=%b addr=%h, required 1 000000c",
                             seen_wr, MEM_ADDRESS);
                end
            end
            if (!BUSYWAIT) break;
        end
        n_checks++;
        if (BUSYWAIT !== 1'b0 || waited != 13 || READDATA !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL dirty_miss_done: busy=%b cycles=%0d data=%h, required 0 13 cafef00d",
                     BUSYWAIT, waited, READDATA);
        end
        n_checks++;
        if (!wb_valid || wb_addr !== 28'h4 || wb_line[31:0] !== 32'h12345ADD
            || wb_line[127:96] !== 32'h33333333) begin
            n_fail++;
            $display("FAIL wb_memory: valid=%b addr=%h line=%h, required 1 0000004 33333333..12345add",
                     wb_valid, wb_addr, wb_line);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic seen_rd;
        logic done;
        seen_rd = 1'b0;
        done = 1'b0;
        hold_busy = 1'b1;
        @(negedge clk);
        ADDRESS = 32'h40;
        READ_WRITE = RD_W;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (MEM_READ) begin
                seen_rd = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen_rd || MEM_WRITE !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_miss_fetch: seen_rd=%b wr=%b, required 1 0", seen_rd, MEM_WRITE);
        end
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        hold_busy = 1'b0;
        #1;
        n_checks++;
        if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_abort: rd=%b wr=%b addr=%h, required 0 0 0",
                     MEM_READ, MEM_WRITE, MEM_ADDRESS);
        end
        n_checks++;
        if (BUSYWAIT !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_remiss: busy=%b, required 1", BUSYWAIT);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!BUSYWAIT) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!done || READDATA !== 32'h12345ADD) begin
            n_fail++;
            $display("FAIL refill_after_reset: done=%b data=%h, required 1 12345add", done, READDATA);
        end
    endtask

    task automatic test_nop_ops();
        logic req;
        req = 1'b0;
        @(negedge clk);
        ADDRESS = 32'hC0;
        WRITEDATA = 32'hFFFFFFFF;
        READ_WRITE = 4'b1110;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL op11_busy: busy=%b, required 0", BUSYWAIT);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = req | MEM_READ | MEM_WRITE | BUSYWAIT;
        end
        @(negedge clk);
        ADDRESS = 32'h80;
        READ_WRITE = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = req | MEM_READ | MEM_WRITE | BUSYWAIT;
        end
        n_checks++;
        if (req !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_no_requests: activity=%b, required 0", req);
        end
        @(negedge clk);
        ADDRESS = 32'h40;
        READ_WRITE = RD_W;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0 || READDATA !== 32'h12345ADD) begin
            n_fail++;
            $display("FAIL nop_unchanged: busy=%b data=%h, required 0 12345add", BUSYWAIT, READDATA);
        end
    endtask

    task automatic test_back_to_back();
        logic done;
        done = 1'b0;
        @(negedge clk);
        ADDRESS = 32'h104;
        WRITEDATA = 32'h13579BDF;
        READ_WRITE = WR_W;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!BUSYWAIT) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL write_miss_done: busy=%b, required 0", BUSYWAIT);
        end
        @(negedge clk);
        READ_WRITE = RD_W;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0 || READDATA !== 32'h13579BDF) begin
            n_fail++;
            $display("FAIL write_allocate: busy=%b data=%h, required 0 13579bdf", BUSYWAIT, READDATA);
        end
        @(negedge clk);
        ADDRESS = 32'h100;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0 || READDATA !== 32'h0A0A0A00) begin
            n_fail++;
            $display("FAIL allocate_fill: busy=%b data=%h, required 0 0a0a0a00", BUSYWAIT, READDATA);
        end
        @(negedge clk);
        READ_WRITE = 4'b0000;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        hold_busy = 1'b0;
        wb_valid = 1'b0;
        wb_addr = '0;
        wb_line = '0;
        cnt = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0]  = {32'h0A0A0A03, 32'h0A0A0A02, 32'h0A0A0A01, 32'h0A0A0A00};
        mem[4]  = {32'h33333333, 32'h22222222, 32'h11111111, 32'hAABBCCDD};
        mem[12] = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hCAFEF00D};
        test_reset();
        test_read_miss();
        test_read_hit();
        test_store_merge();
        test_dirty_miss();
        test_reset_mid_fetch();
        test_nop_ops();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache for the MEM stage.
- Responder for the EX/MEM pipeline register outputs: ALU_RESULT is the address, DATA2 is the store data, READ_WRITE is the access control.
- Drives BUSYWAIT back to stall every pipeline register. Talks to a slow 128-bit-line main memory over a request/busywait handshake.

Parameters:
- LINES, 8, number of cache lines (power of 2, min 2); 16-byte lines (4 words); index = ADDRESS[4+log2(LINES)-1:4]; tag = remaining upper address bits.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- ADDRESS  in  32  byte address (EX/MEM ALU result).
- WRITEDATA  in  32  store data, right-aligned (EX/MEM DATA2).
- READ_WRITE  in  4  [3:2] op: 00 none, 01 read, 10 write, 11 reserved (treated as none); [1:0] size: 00 byte, 01 half, 10 word, 11 treated as word.
- READDATA  out  32  full aligned word containing the address; load extension/selection is done downstream.
- BUSYWAIT  out  1  stall request to the pipeline.
- MEM_READ  out  1  line fetch request.
- MEM_WRITE  out  1  line writeback request.
- MEM_ADDRESS  out  28  line address (ADDRESS[31:4]).
- MEM_WRITEDATA  out  128  victim line; word 0 in [31:0].
- MEM_READDATA  in  128  fetched line.
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Storage per line: valid, dirty, tag, and 128-bit data.
- Word select is ADDRESS[3:2]. Misaligned low bits are ignored: half uses ADDRESS[1], word ignores [1:0].
- Hit means the access is valid and the line is valid and the stored tag equals the address tag.
- BUSYWAIT is combinational: (access valid AND NOT hit) OR (state != IDLE).
  - Asserted in the same cycle as a missing request, so the upstream register holds.
- READDATA is combinational from the indexed line and word. It is don't-care when BUSYWAIT=1 or no read is active.
- FSM states: IDLE, WRITEBACK, FETCH.
  - IDLE, read hit: data returned the same cycle, no stall.
  - IDLE, write hit: byte lanes merged at the posedge, dirty set, no stall.
    - Byte lane = ADDRESS[1:0].
    - Half lanes = ADDRESS[1]*2 .. +1.
    - Word writes all four bytes.
  - IDLE, miss with victim valid and dirty: go to WRITEBACK.
  - IDLE, miss otherwise: go to FETCH.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={victim tag, index}, MEM_WRITEDATA=victim line.
    - Completes on the first posedge with MEM_WRITE=1 and MEM_BUSYWAIT=0, then go to FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4].
    - Completes on the first posedge with MEM_READ=1 and MEM_BUSYWAIT=0.
    - On completion, write MEM_READDATA into the line, set valid, clear dirty, load tag, go to IDLE.
  - Back in IDLE, the still-held request now hits and is serviced that cycle (write merges then and sets dirty).
- Memory contract: memory holds MEM_BUSYWAIT high from the request cycle until data is valid or the write is done. MEM_READ and MEM_WRITE are never both high.
- Request outputs are registered with state. Once raised, MEM_ADDRESS and MEM_WRITEDATA stay stable until completion.
- Miss latency:
  - Clean miss: 1 detect cycle + memory cycles + 1 hit cycle.
  - Dirty miss: adds the writeback transaction.
- Op 00 or 11: no state change, BUSYWAIT=0 (when IDLE).
- RESET (synchronous, any state including mid-transaction):
  - All valid and dirty bits cleared; state=IDLE.
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - BUSYWAIT=0 unless a request is presented after reset (it will then miss).
  - Any in-flight memory transaction is abandoned.
  - Data array contents are not cleared.

Test Plan:
- Reset, then read word @0x0000_0040, memory returns line {0x33..,0x22..,0x11..,0xAABBCCDD} after 5 cycles -> BUSYWAIT high the same cycle, MEM_READ=1 with MEM_ADDRESS=0x0000004, READDATA=0xAABBCCDD on the hit cycle, BUSYWAIT low.
- Read @0x0000_0040 again -> hit, BUSYWAIT=0 the same cycle, no MEM_READ.
- SB 0x5A @0x41, SH 0x1234 @0x42, then LW @0x40 -> all hits, READDATA=0x12345ADD, dirty set.
- LW @0x0000_00C0 (same index as 0x40 for LINES=8, different tag) -> MEM_WRITE first with MEM_ADDRESS=0x0000004, MEM_WRITEDATA[31:0]=0x12345ADD; then MEM_READ with 0x000000C; then hit.
- Assert RESET during FETCH with MEM_BUSYWAIT high -> next cycle MEM_READ=0, state IDLE; LW @0x40 misses again.
- Op 11 and op 00 with any address -> BUSYWAIT=0, no memory requests, cache contents unchanged.
